// File: rtl/io_uart_port.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers on a zero-wait-state CPU IO bus,
// independent TX and RX state machines, CLKS_PER_BIT clock cycles per serial bit.
module io_uart_port #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- decode
  logic sel_data, sel_stat;
  logic rd_data, rd_stat, wr_data;

  assign sel_data = io_addr[12];
  assign sel_stat = !io_addr[12] && io_addr[13];
  assign rd_data  = io_rd && sel_data;
  assign rd_stat  = io_rd && sel_stat;
  assign wr_data  = io_wr && sel_data;

  logic unused_bits;
  assign unused_bits = &{1'b0, io_addr[15:14], io_addr[11:0], wdata[15:8]};

  // ---------------------------------------------------------------- TX
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  tx_state_t   tx_state, tx_state_nx;
  logic [15:0] tx_cnt, tx_cnt_nx;
  logic [2:0]  tx_bit, tx_bit_nx;
  logic [7:0]  tx_shift, tx_shift_nx;
  logic        tx_ready;

  assign tx_ready = (tx_state == TX_IDLE);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_bit   <= tx_bit_nx;
      tx_shift <= tx_shift_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    case (tx_state)
      TX_IDLE: begin
        // Writes while busy fall through here untouched, i.e. are dropped.
        if (wr_data) begin
          tx_state_nx = TX_START;
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_shift_nx = wdata[7:0];
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nx = TX_DATA;
          tx_cnt_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nx   = '0;
          tx_shift_nx = {1'b0, tx_shift[7:1]};
          if (tx_bit == 3'd7) begin
            tx_state_nx = TX_STOP;
          end else begin
            tx_bit_nx = tx_bit + 3'd1;
          end
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_nx = TX_IDLE;
          tx_cnt_nx   = '0;
        end else begin
          tx_cnt_nx = tx_cnt + 16'd1;
        end
      end
      default: begin
        tx_state_nx = TX_IDLE;
        tx_cnt_nx   = '0;
      end
    endcase
  end

  // Decoded from state so an asynchronous reset returns the line high at once.
  always_comb begin
    case (tx_state)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = tx_shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [1:0]  rx_sync;
  logic        rx_s;
  rx_state_t   rx_state, rx_state_nx;
  logic [15:0] rx_cnt, rx_cnt_nx;
  logic [2:0]  rx_bit, rx_bit_nx;
  logic [7:0]  rx_shift, rx_shift_nx;
  logic        rx_done;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rx};
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_done     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_nx = RX_START;
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
        end
      end
      RX_START: begin
        // Half a bit in: still low means a real start bit, high means a glitch.
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nx   = '0;
          rx_state_nx = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_nx = RX_STOP;
          end else begin
            rx_bit_nx = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_nx = RX_IDLE;
          rx_cnt_nx   = '0;
          rx_done     = rx_s;
        end else begin
          rx_cnt_nx = rx_cnt + 16'd1;
        end
      end
      default: begin
        rx_state_nx = RX_IDLE;
        rx_cnt_nx   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- status
  logic [7:0] rx_hold;
  logic       rx_valid;
  logic       overrun;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_hold  <= 8'h00;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // A same-cycle DATA read frees the holding register for the new byte.
      if (rx_done) begin
        if (!rx_valid || rd_data) begin
          rx_hold  <= rx_shift;
          rx_valid <= 1'b1;
        end
      end else if (rd_data) begin
        rx_valid <= 1'b0;
      end

      if (rx_done && rx_valid && !rd_data) begin
        overrun <= 1'b1;
      end else if (rd_stat) begin
        overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (sel_data) begin
      rdata = {8'h00, rx_hold};
    end else if (sel_stat) begin
      rdata = {13'b0, overrun, rx_valid, tx_ready};
    end
  end

endmodule

// File: tb/tb_io_uart_port.sv
// Randomized bench for io_uart_port at CLKS_PER_BIT=4, checked against a
// frame-level model of the register file and serial line.
module tb_io_uart_port;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        resetq;
  logic        io_rd, io_wr;
  logic [15:0] io_addr, wdata, rdata;
  logic        uart_rx, uart_tx;

  int n_vec = 0;
  int n_err = 0;

  // model of the CPU-visible receive state
  logic [7:0] m_hold;
  logic       m_valid, m_ovr;

  io_uart_port #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .io_rd   (io_rd),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] a_data();
    logic [15:0] a;
    a = 16'($urandom);
    a[12] = 1'b1;
    return a;
  endfunction

  function automatic logic [15:0] a_stat();
    logic [15:0] a;
    a = 16'($urandom);
    a[12] = 1'b0;
    a[13] = 1'b1;
    return a;
  endfunction

  function automatic logic [15:0] a_none();
    logic [15:0] a;
    a = 16'($urandom);
    a[12] = 1'b0;
    a[13] = 1'b0;
    return a;
  endfunction

  // Serial line level for bit slot idx of an 8N1 frame (0 = start, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input logic stopb, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return stopb;
  endfunction

  function automatic logic [15:0] stat_exp();
    return {13'b0, m_ovr, m_valid, 1'b1};
  endfunction

  task automatic model_reset();
    m_hold  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock edge of the receive register rules: optional delivery plus optional reads.
  task automatic model_apply(input bit deliver, input logic [7:0] b, input bit rd_d, input bit rd_s);
    bit set_ovr;
    set_ovr = 0;
    if (deliver) begin
      if (!m_valid || rd_d) begin
        m_hold  = b;
        m_valid = 1'b1;
      end else begin
        set_ovr = 1;
      end
    end else if (rd_d) begin
      m_valid = 1'b0;
    end
    if (set_ovr) m_ovr = 1'b1;
    else if (rd_s) m_ovr = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] v);
    io_addr = a;
    #1 v = rdata;
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] v;
    peek(a_stat(), v);
    chk({tag, "_stat"}, v, stat_exp());
    peek(a_data(), v);
    chk({tag, "_data"}, v, {8'h00, m_hold});
    peek(a_none(), v);
    chk({tag, "_unsel"}, v, 16'h0000);
  endtask

  task automatic peek_stat_is(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    peek(a_stat(), v);
    chk(tag, v, exp);
  endtask

  task automatic peek_data_is(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    peek(a_data(), v);
    chk(tag, v, exp);
  endtask

  task automatic start_write(input logic [7:0] b);
    @(negedge clk);
    io_wr   = 1'b1;
    io_addr = a_data();
    wdata   = {8'($urandom), b};
  endtask

  // Follows a write accepted on the preceding edge through the whole frame.
  task automatic tx_frame(input logic [7:0] b, input int drop_j, input bit chain, input logic [7:0] nb);
    logic [15:0] v;
    for (int j = 0; j < 10*CPB; j++) begin
      @(negedge clk);
      io_wr = 1'b0;
      peek(a_stat(), v);
      chk("tx_line", {15'b0, uart_tx}, {15'b0, frame_bit(b, 1'b1, j / CPB)});
      chk("tx_busy", {15'b0, v[0]}, 16'h0000);
      if (j == drop_j) begin
        io_wr   = 1'b1;
        io_addr = a_data();
        wdata   = 16'hEE12;
      end
    end
    @(negedge clk);
    io_wr = 1'b0;
    peek(a_stat(), v);
    chk("tx_idle_line", {15'b0, uart_tx}, 16'h0001);
    chk("tx_ready_back", {15'b0, v[0]}, 16'h0001);
    if (chain) begin
      io_wr   = 1'b1;
      io_addr = a_data();
      wdata   = {8'($urandom), nb};
    end
  endtask

  // Drives one frame; mode 1/2 puts a DATA/STATUS read on the delivery edge.
  task automatic rx_frame(input logic [7:0] b, input logic stopb, input int mode);
    logic [15:0] v;
    for (int k = 0; k < 10*CPB; k++) begin
      @(negedge clk);
      uart_rx = frame_bit(b, stopb, k / CPB);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    io_addr = (mode == 1) ? a_data() : (mode == 2) ? a_stat() : a_none();
    io_rd   = (mode != 0);
    #1 v = rdata;
    if (mode == 1)      chk("rx_coinc_data", v, {8'h00, m_hold});
    else if (mode == 2) chk("rx_coinc_stat", v, stat_exp());
    else                chk("rx_unsel", v, 16'h0000);
    model_apply(stopb, b, mode == 1, mode == 2);
    @(negedge clk);
    io_rd = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_rd(input bit is_data, input string tag);
    logic [15:0] v;
    @(negedge clk);
    io_addr = is_data ? a_data() : a_stat();
    io_rd   = 1'b1;
    #1 v = rdata;
    chk(tag, v, is_data ? {8'h00, m_hold} : stat_exp());
    model_apply(0, 8'h00, is_data, !is_data);
    @(negedge clk);
    io_rd = 1'b0;
  endtask

  initial begin
    logic [7:0] b, nb;
    logic       stopb;
    int         mode;

    resetq  = 1'b0;
    io_rd   = 1'b0;
    io_wr   = 1'b0;
    io_addr = 16'h0000;
    wdata   = 16'h0000;
    uart_rx = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tx", {15'b0, uart_tx}, 16'h0001);
    peek_stat_is("rst_stat", 16'h0001);
    peek_data_is("rst_data", 16'h0000);
    @(negedge clk);
    resetq = 1'b1;
    repeat (2) @(negedge clk);

    // 0x55 with high byte ignored, and a mid-frame write that must be dropped
    start_write(8'h55);
    wdata = 16'hAB55;
    tx_frame(8'h55, 13, 1'b0, 8'h00);
    for (int i = 0; i < 4*CPB; i++) begin
      @(negedge clk);
      chk("tx_no_second", {15'b0, uart_tx}, 16'h0001);
    end

    // back-to-back random frames
    b = 8'($urandom);
    start_write(b);
    for (int i = 0; i < 6; i++) begin
      nb = 8'($urandom);
      tx_frame(b, -1, i < 5, nb);
      b = nb;
    end
    repeat (2) @(negedge clk);

    // receive path, directed
    rx_frame(8'hC3, 1'b1, 0);
    peek_stat_is("c3_stat", 16'h0003);
    cpu_rd(1, "c3_read");
    peek_stat_is("c3_stat_after", 16'h0001);

    rx_frame(8'h11, 1'b1, 0);
    rx_frame(8'h22, 1'b1, 0);
    peek_data_is("ovr_data", 16'h0011);
    peek_stat_is("ovr_stat", 16'h0007);
    cpu_rd(0, "ovr_stat_rd");
    peek_stat_is("ovr_cleared", 16'h0003);
    cpu_rd(1, "ovr_data_rd");
    peek_stat_is("ovr_done", 16'h0001);

    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    peek_stat_is("glitch_stat", 16'h0001);
    rx_frame(8'h5A, 1'b0, 0);
    peek_stat_is("badstop_stat", 16'h0001);
    check_regs("badstop");

    rx_frame(8'h3C, 1'b1, 0);
    rx_frame(8'h96, 1'b1, 1);
    peek_data_is("coinc_rd_data", 16'h0096);
    peek_stat_is("coinc_rd_stat", 16'h0003);
    rx_frame(8'h69, 1'b1, 2);
    peek_stat_is("coinc_set_wins", 16'h0007);
    cpu_rd(0, "coinc_stat_rd");
    cpu_rd(1, "coinc_data_rd");
    check_regs("coinc");

    // reset in the middle of TX data bit 3, with a byte pending in RX
    rx_frame(8'hE7, 1'b1, 0);
    start_write(8'hA5);
    for (int j = 0; j <= 4*CPB + 1; j++) begin
      @(negedge clk);
      io_wr = 1'b0;
      chk("pre_rst_line", {15'b0, uart_tx}, {15'b0, frame_bit(8'hA5, 1'b1, j / CPB)});
    end
    resetq = 1'b0;
    model_reset();
    #1 chk("rst_mid_tx", {15'b0, uart_tx}, 16'h0001);
    @(negedge clk);
    resetq = 1'b1;
    peek_stat_is("rst_mid_stat", 16'h0001);
    check_regs("rst_mid");
    start_write(8'h0F);
    tx_frame(8'h0F, -1, 1'b0, 8'h00);

    // randomized receive traffic with random reads
    for (int i = 0; i < 16; i++) begin
      b     = 8'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      mode  = int'($urandom_range(0, 2));
      rx_frame(b, stopb, mode);
      check_regs("rnd");
      if ($urandom_range(0, 2) == 0) cpu_rd(0, "rnd_stat_rd");
      if ($urandom_range(0, 1) == 0) cpu_rd(1, "rnd_data_rd");
    end
    check_regs("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_uart_port.md
IO_UART_PORT -- requirements
Module: io_uart_port

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clock cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port resetq  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port io_rd  input  1  CPU IO read strobe, one cycle per access.
REQ-005 SHALL have port io_wr  input  1  CPU IO write strobe, one cycle per access.
REQ-006 SHALL have port io_addr  input  16  CPU IO address, valid while io_rd/io_wr high.
REQ-007 SHALL have port wdata  input  16  CPU write data, valid while io_wr high.
REQ-008 SHALL have port rdata  output  16  read data returned to the CPU.
REQ-009 SHALL have port uart_rx  input  1  asynchronous serial input, idle high.
REQ-010 SHALL have port uart_tx  output  1  serial output, idle high.

Function
REQ-011 SHALL decode DATA when io_addr[12]=1 and STATUS when io_addr[12]=0 and io_addr[13]=1; all other address bits ignored.
REQ-012 SHALL drive rdata combinationally in the same cycle as io_rd (zero-wait-state): DATA -> {8'h00, rx_hold}; STATUS -> {13'b0, overrun, rx_valid, tx_ready}; unselected -> 16'h0000.
REQ-013 SHALL drive rdata independent of io_rd (decode on io_addr only); side effects occur only on io_rd.
REQ-014 SHALL clear rx_valid on the clock edge ending an io_rd to DATA.
REQ-015 SHALL clear overrun on the clock edge ending an io_rd to STATUS.
REQ-016 SHALL, on io_wr to DATA while tx_ready=1, latch wdata[7:0] and start a frame; wdata[15:8] ignored.
REQ-017 SHALL silently drop io_wr to DATA while tx_ready=0; io_wr to STATUS has no effect.
REQ-018 SHALL implement TX FSM IDLE -> START -> DATA -> STOP -> IDLE; each bit held exactly CLKS_PER_BIT cycles; 8N1, LSB first.
REQ-019 SHALL drive uart_tx low for START the cycle after the accepted write, and tx_ready=0 from that same cycle.
REQ-020 SHALL restore tx_ready=1 the cycle after the full-length STOP bit completes (frame = 10*CLKS_PER_BIT cycles); a write in that cycle is accepted back-to-back.
REQ-021 SHALL pass uart_rx through a two-flop synchronizer before use.
REQ-022 SHALL implement RX FSM IDLE -> START -> DATA -> STOP -> IDLE.
REQ-023 SHALL leave IDLE on a synchronized falling level (low sample); START waits CLKS_PER_BIT/2 cycles, then re-samples: low -> DATA, high -> IDLE (glitch rejected).
REQ-024 SHALL sample each of the 8 data bits CLKS_PER_BIT cycles apart (mid-bit), LSB first.
REQ-025 SHALL sample the stop bit mid-bit: high -> byte delivered; low -> byte discarded, no flag change; both return to IDLE.
REQ-026 SHALL, on delivery with rx_valid=0, load rx_hold and set rx_valid.
REQ-027 SHALL, on delivery with rx_valid=1 and no same-cycle DATA read, keep old rx_hold and set overrun.
REQ-028 SHALL, on delivery in the same cycle as an io_rd to DATA, load the new byte, keep rx_valid=1, not set overrun.
REQ-029 SHALL give set priority over clear when overrun set and STATUS read coincide.
REQ-030 SHALL run TX and RX fully independently; simultaneous io_wr and io_rd are each honoured.

Reset
REQ-031 SHALL, while resetq=0, force uart_tx=1, tx_ready=1, rx_valid=0, overrun=0, rx_hold=8'h00, both FSMs IDLE, counters 0, synchronizer flops 1.
REQ-032 SHALL abort any in-flight frame when reset is asserted mid-frame; uart_tx returns high immediately (asynchronous).
REQ-033 SHALL resume normal operation on the first clock edge after resetq deasserts.

Verification (CLKS_PER_BIT=4)
REQ-034 SHALL cover: io_wr DATA wdata=16'hAB55 -> uart_tx: 4 low, bits 1,0,1,0,1,0,1,0 x4 each, 4 high; STATUS bit0=0 for 40 cycles, then 1.
REQ-035 SHALL cover: second write 0x12 mid-frame -> dropped; only 0x55 transmitted.
REQ-036 SHALL cover: drive frame 0xC3 on uart_rx -> STATUS=16'h0003; DATA read returns 16'h00C3; next STATUS=16'h0001.
REQ-037 SHALL cover: two frames 0x11, 0x22 without reading -> DATA=16'h0011, STATUS=16'h0007; STATUS read clears overrun -> STATUS=16'h0003, then DATA read -> STATUS=16'h0001.
REQ-038 SHALL cover: 1-cycle low glitch on uart_rx -> no delivery; frame 0x5A with low stop bit -> STATUS unchanged at 16'h0001.
REQ-039 SHALL cover: resetq pulsed low during TX bit 3 -> uart_tx=1 same cycle, STATUS=16'h0001 after release, new write 0x0F transmits correctly.
